// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_ifid_reg.sv
// IF/ID pipeline register: load captures {instr, pc, pc+4}; flush squashes to NOP, keeping pc fields.
// Latency: one edge. Backpressure: neither load nor flush holds every field.
// Priority: reset > flush > load > hold.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= 32'h0;
            pc4   <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= fetch_instr;
            pc    <= fetch_pc;
            pc4   <= fetch_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, next-PC mux and RUN/HALT FSM; optional IFETCH_MISALIGN_EN halts on bad targets.
// Latency: ROM word appears on id_instr one edge after pc addresses it; a redirect costs one bubble.
// Backpressure: stall freezes pc and IF/ID; redirect overrides stall.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        misalign
);

    ifetch_state_t state, next_state;
    logic [31:0]   pc, next_pc;
    logic          load, flush;
`ifdef IFETCH_MISALIGN_EN
    logic          set_misalign;
    logic          misalign_q;
`endif

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= next_pc;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef IFETCH_MISALIGN_EN
        set_misalign = 1'b0;
`endif
        case (state)
            RUN: begin
                if (redirect) begin
                    flush = 1'b1;
`ifdef IFETCH_MISALIGN_EN
                    // A misaligned target is fatal: pc stays put and fetch stops.
                    if (redirect_pc[1:0] != 2'b00) begin
                        set_misalign = 1'b1;
                        next_state   = HALT;
                    end else begin
                        next_pc = redirect_pc;
                    end
`else
                    next_pc = redirect_pc & ~32'h3;
`endif
                end else if (!stall) begin
                    load    = 1'b1;
                    next_pc = pc + PC_STEP;
                end
            end
            HALT: begin
                flush = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

`ifdef IFETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (set_misalign) begin
            misalign_q <= 1'b1;
        end
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    ifid_reg u_ifid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .flush       (flush),
        .fetch_instr (imem_rdata),
        .fetch_pc    (pc),
        .valid       (id_valid),
        .instr       (id_instr),
        .pc          (id_pc),
        .pc4         (id_pc4)
    );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed program-ROM scenarios plus randomized stall/redirect traffic against a reference model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid, misalign;
    logic [31:0] id_instr, id_pc, id_pc4;

    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
    logic        w_valid, w_mis;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4;
    logic        m_valid, m_mis, m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : (imem_addr ^ 32'hA5A5_0000);
    assign w_rdata    = (w_addr < 32'd256) ? mem[w_addr[7:2]] : (w_addr ^ 32'hA5A5_0000);

    ifetch dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
        .misalign(misalign)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc), .id_pc4(w_pc4),
        .misalign(w_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
        m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_mis = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [31:0] tgt);
        if (m_halt) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end else if (rd) begin
            m_valid = 1'b0; m_instr = 32'h0;
`ifdef IFETCH_MISALIGN_EN
            if (tgt[1:0] != 2'b00) begin
                m_mis = 1'b1; m_halt = 1'b1;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = {tgt[31:2], 2'b00};
`endif
        end else if (!st) begin
            m_valid = 1'b1; m_instr = rom(m_pc);
            m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, m_valid});
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".pc"},    id_pc, m_id_pc);
        chk({tag, ".pc4"},   id_pc4, m_id_pc4);
        chk({tag, ".mis"},   {31'h0, misalign}, {31'h0, m_mis});
    endtask

    // Apply inputs, clock one edge, sample 1ns later and compare against the model.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input string tag);
        stall = st; redirect = rd; redirect_pc = tgt;
        @(posedge clk);
        model_edge(st, rd, tgt);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check_model("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0000; mem[1]  = 32'h2008_0004; mem[2]  = 32'h2009_000D;
        mem[3]  = 32'h0109_5020; mem[4]  = 32'h010A_5020;
        mem[14] = 32'h0128_402A; mem[15] = 32'h1100_FFFE;

        do_reset();
        chk("wrap.reset_valid", {31'h0, w_valid}, 32'h0);
        chk("wrap.reset_addr", w_addr, 32'hFFFF_FFF8);

        // Free run from reset
        step(1'b0, 1'b0, 32'h0, "run1");
        chk("run1.instr_k", id_instr, 32'h0000_0000);
        chk("run1.pc_k", id_pc, 32'h0);
        chk("run1.pc4_k", id_pc4, 32'h4);
        chk("wrap1.pc", w_pc, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0, "run2");
        chk("run2.instr_k", id_instr, 32'h2008_0004);
        chk("run2.pc_k", id_pc, 32'h4);
        chk("wrap2.pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap2.pc4", w_pc4, 32'h0);
        step(1'b0, 1'b0, 32'h0, "run3");
        chk("run3.instr_k", id_instr, 32'h2009_000D);
        chk("run3.pc_k", id_pc, 32'h8);
        chk("wrap3.pc", w_pc, 32'h0);
        chk("wrap3.instr", w_instr, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0, "run4");

        // Stall three cycles at pc=0x10
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, "stall");
            chk("stall.addr_k", imem_addr, 32'h10);
            chk("stall.pc_k", id_pc, 32'hC);
            chk("stall.instr_k", id_instr, 32'h0109_5020);
        end
        step(1'b0, 1'b0, 32'h0, "release");
        chk("release.instr_k", id_instr, 32'h010A_5020);
        chk("release.pc_k", id_pc, 32'h10);

        // Advance to pc=0x40, then redirect to 0x38
        while (m_pc != 32'h40) step(1'b0, 1'b0, 32'h0, "adv");
        chk("pre_redir.addr_k", imem_addr, 32'h40);
        step(1'b0, 1'b1, 32'h38, "redir");
        chk("redir.valid_k", {31'h0, id_valid}, 32'h0);
        chk("redir.instr_k", id_instr, 32'h0);
        step(1'b0, 1'b0, 32'h0, "redir_tgt");
        chk("redir_tgt.instr_k", id_instr, 32'h0128_402A);
        chk("redir_tgt.pc_k", id_pc, 32'h38);

        // Redirect and stall together: redirect wins
        step(1'b1, 1'b1, 32'h3C, "rs");
        chk("rs.valid_k", {31'h0, id_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, "rs_tgt");
        chk("rs_tgt.instr_k", id_instr, 32'h1100_FFFE);

        // Randomized aligned traffic
        for (int i = 0; i < 300; i++) begin
            logic st, rd;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 99) < 15);
            tgt = {24'h0, $urandom_range(0, 63) << 2};
            step(st, rd, tgt, "rand");
        end

        // Mid-stream reset discards IF/ID
        do_reset();
        step(1'b0, 1'b0, 32'h0, "restart");
        step(1'b0, 1'b0, 32'h0, "restart");

        // Misaligned redirect; with the feature absent the target is masked to 0x20
        step(1'b0, 1'b1, 32'h22, "mis");
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {24'h0, $urandom_range(0, 63) << 2}, "mis_hold");
        end
`ifdef IFETCH_MISALIGN_EN
        chk("mis.flag_k", {31'h0, misalign}, 32'h1);
        chk("mis.valid_k", {31'h0, id_valid}, 32'h0);
        chk("mis.addr_k", imem_addr, 32'h8);
`else
        chk("mis.flag_k", {31'h0, misalign}, 32'h0);
`endif
        do_reset();
        chk("post_reset.mis_k", {31'h0, misalign}, 32'h0);
        step(1'b0, 1'b0, 32'h0, "post_reset");
        chk("post_reset.pc_k", id_pc, 32'h0);
        chk("post_reset.valid_k", {31'h0, id_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
